// File: rtl/time_pkg.sv
// Shared key codes, state encoding and field limits for keyboard time entry.
package time_pkg;

    localparam logic [7:0] KEY_SET    = 8'h73;
    localparam logic [7:0] KEY_ALARM  = 8'h61;
    localparam logic [7:0] KEY_DONE   = 8'h64;
    localparam logic [7:0] KEY_ESC    = 8'h1B;
    localparam logic [7:0] KEY_BS     = 8'h08;
    localparam logic [7:0] KEY_DISARM = 8'h78;

    localparam logic [6:0] MIN_LIMIT  = 7'd60;
    localparam logic [6:0] SEC_LIMIT  = 7'd60;
    localparam logic [2:0] NUM_DIGITS = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET   = 2'd1,
        ALARM = 2'd2
    } state_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

endpackage

// File: rtl/time_entry_ctrl_bcd_pair_to_bin.sv
// Combinational conversion of one BCD tens/units pair to a 7-bit binary value.
module bcd_pair_to_bin (
    input  logic [3:0] tens,
    input  logic [3:0] units,
    output logic [6:0] bin
);
    logic [6:0] tens_w;
    logic [6:0] units_w;

    assign tens_w  = {3'b000, tens};
    assign units_w = {3'b000, units};
    assign bin     = (tens_w * 7'd10) + units_w;

endmodule

// File: rtl/time_entry_ctrl.sv
// Keyboard-driven SET/ALARM entry over an HHMMSS BCD buffer, with commit
// validation, alarm storage, alarm-match detection and a timed ring output.
module time_entry_ctrl
    import time_pkg::*;
#(
    parameter int RING_SECONDS = 30,
    parameter int HOUR_LIMIT   = 24
) (
    input  logic        CLK_50,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [7:0]  key_ascii,
    input  logic        sec_tick,
    input  logic [5:0]  cur_hour,
    input  logic [5:0]  cur_minute,
    input  logic [5:0]  cur_second,
    output logic        set_en,
    output logic        alarm_en,
    output logic [2:0]  entry_pos,
    output logic [23:0] edit_digits,
    output logic        load_time,
    output logic [5:0]  load_hour,
    output logic [5:0]  load_minute,
    output logic [5:0]  load_second,
    output logic [5:0]  alarm_hour,
    output logic [5:0]  alarm_minute,
    output logic [5:0]  alarm_second,
    output logic        alarm_armed,
    output logic        alarm_ring,
    output logic        entry_error
);

    localparam logic [6:0] HOUR_LIM7 = 7'(HOUR_LIMIT);
    localparam logic [5:0] RING_CNT  = 6'(RING_SECONDS);

    state_e      state_q, state_d;
    logic [2:0]  pos_q, pos_d;
    logic [23:0] edit_q, edit_d;
    logic        load_time_q, load_time_d;
    logic        error_q, error_d;
    logic [5:0]  lh_q, lh_d, lm_q, lm_d, ls_q, ls_d;
    logic [5:0]  ah_q, ah_d, am_q, am_d, as_q, as_d;
    logic        armed_q, armed_d;
    logic        ring_q, ring_d;
    logic [5:0]  ring_cnt_q, ring_cnt_d;

    logic [6:0]  pair_bin [3];
    logic        commit_ok;
    logic        match;
    logic        key_act;
    logic [2:0]  pos_m1;

    // Pair 0 is hours, 1 minutes, 2 seconds, taken from the top of the buffer down.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pair
            bcd_pair_to_bin u_pair (
                .tens  (edit_q[23 - 8*gi -: 4]),
                .units (edit_q[19 - 8*gi -: 4]),
                .bin   (pair_bin[gi])
            );
        end
    endgenerate

    assign commit_ok = (pos_q == NUM_DIGITS) && (pair_bin[0] < HOUR_LIM7)
                    && (pair_bin[1] < MIN_LIMIT) && (pair_bin[2] < SEC_LIMIT);
    assign match     = armed_q && (cur_hour == ah_q) && (cur_minute == am_q)
                    && (cur_second == as_q);
    // A key arriving while already ringing only silences the ring.
    assign key_act   = key_valid && !ring_q;
    assign pos_m1    = pos_q - 3'd1;

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        edit_d      = edit_q;
        load_time_d = 1'b0;
        error_d     = 1'b0;
        lh_d        = lh_q;
        lm_d        = lm_q;
        ls_d        = ls_q;
        ah_d        = ah_q;
        am_d        = am_q;
        as_d        = as_q;
        armed_d     = armed_q;
        ring_d      = ring_q;
        ring_cnt_d  = ring_cnt_q;

        if (key_valid && ring_q) begin
            ring_d = 1'b0;
        end

        if (key_act) begin
            case (state_q)
                IDLE: begin
                    if (key_ascii == KEY_SET || key_ascii == KEY_ALARM) begin
                        state_d = (key_ascii == KEY_SET) ? SET : ALARM;
                        pos_d   = 3'd0;
                        edit_d  = 24'h0;
                    end else if (key_ascii == KEY_DISARM) begin
                        armed_d = 1'b0;
                    end
                end
                SET, ALARM: begin
                    if (is_digit(key_ascii)) begin
                        if (pos_q < NUM_DIGITS) begin
                            for (int i = 0; i < 6; i++) begin
                                if (pos_q == 3'(i)) edit_d[(5-i)*4 +: 4] = key_ascii[3:0];
                            end
                            pos_d = pos_q + 3'd1;
                        end
                    end else if (key_ascii == KEY_BS) begin
                        if (pos_q != 3'd0) begin
                            for (int i = 0; i < 6; i++) begin
                                if (pos_m1 == 3'(i)) edit_d[(5-i)*4 +: 4] = 4'h0;
                            end
                            pos_d = pos_m1;
                        end
                    end else if (key_ascii == KEY_ESC) begin
                        state_d = IDLE;
                        pos_d   = 3'd0;
                        edit_d  = 24'h0;
                    end else if (key_ascii == KEY_DONE) begin
                        if (commit_ok) begin
                            if (state_q == SET) begin
                                lh_d        = pair_bin[0][5:0];
                                lm_d        = pair_bin[1][5:0];
                                ls_d        = pair_bin[2][5:0];
                                load_time_d = 1'b1;
                            end else begin
                                ah_d    = pair_bin[0][5:0];
                                am_d    = pair_bin[1][5:0];
                                as_d    = pair_bin[2][5:0];
                                armed_d = 1'b1;
                            end
                            state_d = IDLE;
                            pos_d   = 3'd0;
                            edit_d  = 24'h0;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Match is judged against the registered alarm, so a same-cycle commit sees the old value.
        if (sec_tick) begin
            if (match) begin
                ring_d     = 1'b1;
                ring_cnt_d = RING_CNT;
            end else if (ring_q) begin
                ring_cnt_d = ring_cnt_q - 6'd1;
                if (ring_cnt_q == 6'd1) ring_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_50) begin
        if (rst) begin
            state_q     <= IDLE;
            pos_q       <= 3'd0;
            edit_q      <= 24'h0;
            load_time_q <= 1'b0;
            error_q     <= 1'b0;
            lh_q        <= 6'd0;
            lm_q        <= 6'd0;
            ls_q        <= 6'd0;
            ah_q        <= 6'd0;
            am_q        <= 6'd0;
            as_q        <= 6'd0;
            armed_q     <= 1'b0;
            ring_q      <= 1'b0;
            ring_cnt_q  <= 6'd0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            edit_q      <= edit_d;
            load_time_q <= load_time_d;
            error_q     <= error_d;
            lh_q        <= lh_d;
            lm_q        <= lm_d;
            ls_q        <= ls_d;
            ah_q        <= ah_d;
            am_q        <= am_d;
            as_q        <= as_d;
            armed_q     <= armed_d;
            ring_q      <= ring_d;
            ring_cnt_q  <= ring_cnt_d;
        end
    end

    assign set_en       = (state_q == SET);
    assign alarm_en     = (state_q == ALARM);
    assign entry_pos    = pos_q;
    assign edit_digits  = edit_q;
    assign load_time    = load_time_q;
    assign load_hour    = lh_q;
    assign load_minute  = lm_q;
    assign load_second  = ls_q;
    assign alarm_hour   = ah_q;
    assign alarm_minute = am_q;
    assign alarm_second = as_q;
    assign alarm_armed  = armed_q;
    assign alarm_ring   = ring_q;
    assign entry_error  = error_q;

endmodule
